// File: rtl/spi_arbiter_pkg.sv
// Shared types for the SPI master arbiter: FSM state encoding and the
// n_clks field-width helper used by the arbiter and its interface.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } spi_arb_state_t;

  // Field must hold the value SPI_MAXLEN itself, hence the extra bit.
  function automatic int spi_lw(input int maxlen);
    return $clog2(maxlen) + 1;
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Bundle of requester-side and SPIMaster-side signals of the arbiter.
// slave = arbiter view, master = environment (requesters + SPIMaster) view.
interface spi_arbiter_if import spi_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int SPI_MAXLEN = 32
);
  localparam int LW = spi_lw(SPI_MAXLEN);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*LW-1:0]         req_n_clks;
  logic [NUM_REQ*SPI_MAXLEN-1:0] req_tx_data;
  logic [NUM_REQ-1:0]            done;
  logic [SPI_MAXLEN-1:0]         rx_data;
  logic [NUM_REQ-1:0]            grant;
  logic                          m_start_cmd;
  logic                          m_spi_drv_rdy;
  logic [LW-1:0]                 m_n_clks;
  logic [SPI_MAXLEN-1:0]         m_tx_data;
  logic [SPI_MAXLEN-1:0]         m_rx_miso;
  logic                          m_ss_n;
  logic [NUM_REQ-1:0]            ss_n;

  modport slave (
    input  req, req_n_clks, req_tx_data, m_spi_drv_rdy, m_rx_miso, m_ss_n,
    output done, rx_data, grant, m_start_cmd, m_n_clks, m_tx_data, ss_n
  );

  modport master (
    output req, req_n_clks, req_tx_data, m_spi_drv_rdy, m_rx_miso, m_ss_n,
    input  done, rx_data, grant, m_start_cmd, m_n_clks, m_tx_data, ss_n
  );

endinterface

// File: rtl/spi_arbiter_rr_select.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// wrapping past N-1 to 0. Returns both one-hot and binary forms.
module rr_select #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin sharing of one SPIMaster among NUM_REQ requesters; the master's
// SS_N is steered combinationally onto the chip select of the granted slave.
module spi_arbiter import spi_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int SPI_MAXLEN = 32
) (
  input  logic         clk,
  input  logic         sresetn,
  spi_arbiter_if.slave bus
);

  localparam int LW = spi_lw(SPI_MAXLEN);
  localparam int IW = $clog2(NUM_REQ);

  spi_arb_state_t        state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [SPI_MAXLEN-1:0] rx_q, rx_d;
  logic                  start_q, start_d;
  logic [LW-1:0]         nclk_q, nclk_d;
  logic [SPI_MAXLEN-1:0] tx_q, tx_d;

  logic [NUM_REQ-1:0]    sel_gnt;
  logic [IW-1:0]         sel_idx;
  logic [LW-1:0]         sel_nclk;
  logic [LW-1:0]         nclk_arr [NUM_REQ];
  logic [SPI_MAXLEN-1:0] tx_arr   [NUM_REQ];

  rr_select #(.N(NUM_REQ), .IW(IW)) u_rr_select (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .gnt_o (sel_gnt),
    .idx_o (sel_idx)
  );

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign nclk_arr[i]  = bus.req_n_clks[i*LW +: LW];
    assign tx_arr[i]    = bus.req_tx_data[i*SPI_MAXLEN +: SPI_MAXLEN];
    assign bus.ss_n[i]  = grant_q[i] ? bus.m_ss_n : 1'b1;
  end

  assign sel_nclk = (nclk_arr[sel_idx] > LW'(SPI_MAXLEN)) ? LW'(SPI_MAXLEN)
                                                           : nclk_arr[sel_idx];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    rx_d    = rx_q;
    start_d = start_q;
    nclk_d  = nclk_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        if (|bus.req && bus.m_spi_drv_rdy) begin
          grant_d = sel_gnt;
          idx_d   = sel_idx;
          nclk_d  = sel_nclk;
          tx_d    = tx_arr[sel_idx];
          // Zero-length transfers complete without touching the master.
          if (sel_nclk == '0) begin
            rx_d    = '0;
            done_d  = sel_gnt;
            state_d = DONE;
          end else begin
            start_d = 1'b1;
            state_d = START;
          end
        end
      end
      START: begin
        if (!bus.m_spi_drv_rdy) begin
          start_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.m_spi_drv_rdy) begin
          rx_d    = bus.m_rx_miso;
          done_d  = grant_q;
          state_d = DONE;
        end
      end
      DONE: begin
        grant_d = '0;
        ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      rx_q    <= '0;
      start_q <= 1'b0;
      nclk_q  <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      rx_q    <= rx_d;
      start_q <= start_d;
      nclk_q  <= nclk_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.rx_data     = rx_q;
  assign bus.m_start_cmd = start_q;
  assign bus.m_n_clks    = nclk_q;
  assign bus.m_tx_data   = tx_q;

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Round-robin arbiter that shares one SPIMaster instance among NUM_REQ independent requesters.
- Each requester gets a level req/pulse done handshake.
- The arbiter drives the master's start_cmd/n_clks/tx_data interface and routes the returned rx_miso to the winning requester.
- It demultiplexes the master's single SS_N onto per-slave chip selects, one slave per requester.

Parameters:
- NUM_REQ, 4, number of requesters and per-slave chip selects (2..16).
- SPI_MAXLEN, 32, maximum transfer length; must match the SPIMaster instance.
- LW, $clog2(SPI_MAXLEN)+1, width of the n_clks fields (derived, not overridden).

Ports:
- clk  in  1  system clock.
- sresetn  in  1  asynchronous active-low reset (codebase port name kept).
- req  in  NUM_REQ  per-requester transfer request, level.
- req_n_clks  in  NUM_REQ*LW  packed n_clks per requester, slice i = [i*LW +: LW].
- req_tx_data  in  NUM_REQ*SPI_MAXLEN  packed tx data per requester.
- done  out  NUM_REQ  one-cycle completion pulse per requester.
- rx_data  out  SPI_MAXLEN  received data of the last completed transfer.
- grant  out  NUM_REQ  one-hot owner of the current transfer; 0 when idle.
- m_start_cmd  out  1  to SPIMaster start_cmd.
- m_spi_drv_rdy  in  1  from SPIMaster spi_drv_rdy.
- m_n_clks  out  LW  to SPIMaster n_clks.
- m_tx_data  out  SPI_MAXLEN  to SPIMaster tx_data.
- m_rx_miso  in  SPI_MAXLEN  from SPIMaster rx_miso.
- m_ss_n  in  1  from SPIMaster SS_N.
- ss_n  out  NUM_REQ  per-slave chip selects, active low.

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE, grant=0, done=0, rx_data=0, m_start_cmd=0, m_n_clks=0, m_tx_data=0, ss_n=all 1s, rr pointer=0.
- Requester contract:
  - req[i] is held high with stable req_n_clks[i] and req_tx_data[i] until done[i] pulses.
  - Dropping req[i] early does not abort the transfer; done[i] still pulses.
- FSM states: IDLE, START, BUSY, DONE.
- IDLE:
  - If any req is set and m_spi_drv_rdy=1, pick the first set req at or after rr pointer (wrapping past NUM_REQ-1 to 0).
  - Register grant, m_n_clks and m_tx_data from that requester's slice.
  - If the selected n_clks==0, go to DONE with rx_data=0; the master is not started.
  - Otherwise go to START.
  - If m_spi_drv_rdy=0, stay in IDLE and do not grant.
- START:
  - m_start_cmd=1; m_n_clks and m_tx_data stay stable.
  - On the first cycle m_spi_drv_rdy=0, drop m_start_cmd on the next edge and go to BUSY.
- BUSY:
  - Wait for m_spi_drv_rdy=1.
  - On that cycle, capture m_rx_miso into rx_data and go to DONE.
- DONE:
  - done[g]=1 for exactly one cycle.
  - Set rr pointer to g+1 mod NUM_REQ, clear grant, go to IDLE.
- Latency:
  - req rising with the master ready gives m_start_cmd high 1 cycle later.
  - m_spi_drv_rdy rising gives done 1 cycle later.
  - Minimum gap between back-to-back transfers is 1 IDLE cycle.
- Width rules:
  - req_n_clks > SPI_MAXLEN is clamped to SPI_MAXLEN.
  - rx_data holds its value until the next DONE.
- Chip selects: ss_n[i] = m_ss_n when grant[i]=1, else 1. This path is combinational so it does not add skew against SCLK/MOSI.
- Fairness: every continuously requesting requester is served within NUM_REQ transfers.
- Simultaneous events:
  - A requester that completes and re-requests in the same cycle loses priority to the others.
  - With a single active requester, it is served back to back.
- Reset mid-transfer: the FSM returns to IDLE, m_start_cmd=0, ss_n all deasserted. The master's own reset is handled separately by the instantiating level.

Decomposition:
- Package spi_pkg holds:
  - the state enum typedef spi_arb_state_t {IDLE, START, BUSY, DONE};
  - an LW helper function.
- Sub-module rr_select (combinational):
  - inputs: req vector, pointer;
  - outputs: one-hot grant and binary index.
- The top level is the arbiter FSM plus the datapath muxes.

Test Plan:
- Single transfer: req[2]=1, n_clks=8, tx=0xA5, model slave returns 0x3C.
  - m_start_cmd for 1 cycle after req.
  - ss_n=4'b1011 during SS_N low.
  - done[2] pulse with rx_data=0x3C.
- All four requesters held high, tx=0x10..0x13:
  - grant order 0,1,2,3,0.
  - done pulses in that order.
  - each m_tx_data matches its requester.
- Boundary lengths:
  - n_clks=0: done 1 cycle after the IDLE grant, rx_data=0, m_start_cmd never rises.
  - n_clks=40 with SPI_MAXLEN=32: m_n_clks=32.
- Master busy at request: hold m_spi_drv_rdy=0 when req[1] rises.
  - No grant until m_spi_drv_rdy=1.
  - Then start 1 cycle later.
- Reset mid-transfer: assert sresetn=0 in BUSY.
  - Immediately grant=0, ss_n=4'b1111, m_start_cmd=0.
  - After release, the FSM is in IDLE and a new req[0] completes normally.
